// File: rtl/rcc_pkg.sv
// Shared defaults and the per-channel kernel-clock enable equation.
package rcc_pkg;

  localparam int CH_NUM_DEF  = 4;
  localparam int DIV_W_DEF   = 5;
  localparam int DIV_RST_DEF = 0;

  // A channel runs if either core wants it: enabled, and not sleeping unless
  // the low-power enable keeps it alive, and never in deep sleep.
  function automatic logic ker_en_raw(
    input logic c1_en,
    input logic c1_lpen,
    input logic c1_sleep,
    input logic c1_deepsleep,
    input logic c2_en,
    input logic c2_lpen,
    input logic c2_sleep,
    input logic c2_deepsleep
  );
    ker_en_raw = (c1_en & (~c1_sleep | c1_lpen) & ~c1_deepsleep) |
                 (c2_en & (~c2_sleep | c2_lpen) & ~c2_deepsleep);
  endfunction

endpackage

// File: rtl/rcc_ker_div_ch.sv
// One kernel-clock channel: half-period divider, glitch-free gate and
// divider-change handshake that only switches on a falling boundary.
module rcc_ker_div_ch
  import rcc_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_raw,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             ker_clk,
  output logic             clk_active
);

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] div_pend;
  logic             phase;
  logic             gate;
  logic             pend;

  logic             at_top;
  logic             stop;
  logic             apply;

  // Decode the boundary, stop and divider-switch conditions from state.
  always_comb begin
    at_top = (cnt == div_cur);
    // Gate only moves while ker_clk is low, so a low phase with the enable
    // gone parks the channel at once; a high phase always completes.
    stop   = ~gate | (~phase & ~en_raw);
    // New divider lands on the falling boundary, or immediately when idle.
    apply  = pend & (~gate | (phase & at_top));
  end

  // Divider counter, output phase and gate.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      gate  <= 1'b0;
    end else if (stop) begin
      // phase is already 0 whenever stop is true
      cnt   <= '0;
      phase <= 1'b0;
      gate  <= en_raw;
    end else if (at_top) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Current divider and pending request; a request in the apply cycle re-arms.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cur  <= DIV_INIT;
      div_pend <= DIV_INIT;
      pend     <= 1'b0;
    end else begin
      if (apply) div_cur <= div_pend;
      if (div_req) begin
        div_pend <= div_val;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end
    end
  end

  assign div_ack    = apply;
  assign ker_clk    = phase;
  assign clk_active = gate;

endmodule

// File: rtl/rcc_ker_clk_div_ctrl.sv
// Kernel-clock divider/gate controller: enable decode plus CH_NUM channels.
module rcc_ker_clk_div_ctrl
  import rcc_pkg::*;
#(
  parameter int CH_NUM  = CH_NUM_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    c1_sleep,
  input  logic                    c1_deepsleep,
  input  logic                    c2_sleep,
  input  logic                    c2_deepsleep,
  input  logic [CH_NUM-1:0]       c1_en,
  input  logic [CH_NUM-1:0]       c2_en,
  input  logic [CH_NUM-1:0]       c1_lpen,
  input  logic [CH_NUM-1:0]       c2_lpen,
  input  logic [CH_NUM-1:0]       div_req,
  input  logic [CH_NUM*DIV_W-1:0] div_val,
  output logic [CH_NUM-1:0]       div_ack,
  output logic [CH_NUM-1:0]       ker_clk,
  output logic [CH_NUM-1:0]       clk_active
);

  logic [CH_NUM-1:0] en_raw;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign en_raw[i] = ker_en_raw(c1_en[i], c1_lpen[i], c1_sleep, c1_deepsleep,
                                  c2_en[i], c2_lpen[i], c2_sleep, c2_deepsleep);

    rcc_ker_div_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_in     (clk_in),
      .rst        (rst),
      .en_raw     (en_raw[i]),
      .div_req    (div_req[i]),
      .div_val    (div_val[i*DIV_W +: DIV_W]),
      .div_ack    (div_ack[i]),
      .ker_clk    (ker_clk[i]),
      .clk_active (clk_active[i])
    );
  end

endmodule

// File: tb/tb_rcc_ker_clk_div_ctrl.sv
// Directed bench for rcc_ker_clk_div_ctrl (4 channels, DIV_W=5, DIV_RST=0).
module tb_rcc_ker_clk_div_ctrl;

  localparam int CH = 4;
  localparam int DW = 5;

  logic            clk_in = 1'b0;
  logic            rst;
  logic            c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep;
  logic [CH-1:0]   c1_en, c2_en, c1_lpen, c2_lpen, div_req;
  logic [CH*DW-1:0] div_val;
  logic [CH-1:0]   div_ack, ker_clk, clk_active;

  int checks = 0;
  int errors = 0;

  rcc_ker_clk_div_ctrl #(.CH_NUM(CH), .DIV_W(DW), .DIV_RST(0)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .c1_sleep     (c1_sleep),
    .c1_deepsleep (c1_deepsleep),
    .c2_sleep     (c2_sleep),
    .c2_deepsleep (c2_deepsleep),
    .c1_en        (c1_en),
    .c2_en        (c2_en),
    .c1_lpen      (c1_lpen),
    .c2_lpen      (c2_lpen),
    .div_req      (div_req),
    .div_val      (div_val),
    .div_ack      (div_ack),
    .ker_clk      (ker_clk),
    .clk_active   (clk_active)
  );

  always #5 clk_in = ~clk_in;

  // Advance one cycle; inputs driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic req(input int ch, input int v);
    div_val[ch*DW +: DW] = DW'(v);
    div_req[ch] = 1'b1;
    step();
    div_req[ch] = 1'b0;
  endtask

  // Measure one full high and low run of ker_clk[ch] (bounded).
  task automatic measure(input int ch, output int hi, output int lo);
    int n;
    n = 0; hi = 0; lo = 0;
    while (ker_clk[ch] !== 1'b0 && n < 100) begin step(); n++; end
    while (ker_clk[ch] !== 1'b1 && n < 200) begin step(); n++; end
    while (ker_clk[ch] === 1'b1 && hi < 100) begin step(); hi++; end
    while (ker_clk[ch] === 1'b0 && lo < 100) begin step(); lo++; end
  endtask

  task automatic wait_rise(input int ch, output int n);
    n = 0;
    while (ker_clk[ch] !== 1'b1 && n < 60) begin step(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c1_sleep = 0; c1_deepsleep = 0; c2_sleep = 0; c2_deepsleep = 0;
    c1_en = '0; c2_en = '0; c1_lpen = '0; c2_lpen = '0;
    div_req = '0; div_val = '0;
    step(); step();
    checks++; if (ker_clk !== 4'h0) begin errors++; $display("FAIL reset_ker_clk got=%h exp=0", ker_clk); end
    checks++; if (div_ack !== 4'h0) begin errors++; $display("FAIL reset_div_ack got=%h exp=0", div_ack); end
    checks++; if (clk_active !== 4'h0) begin errors++; $display("FAIL reset_clk_active got=%h exp=0", clk_active); end
    rst = 1'b0;
    step(); step();
    checks++; if (clk_active !== 4'h0 || ker_clk !== 4'h0) begin errors++; $display("FAIL idle_after_reset act=%h clk=%h exp=0/0", clk_active, ker_clk); end
  endtask

  task automatic test_div2_then_div4();
    int hi, lo, acks, n;
    logic ack_hi;
    c1_en[0] = 1'b1;
    step();
    checks++; if (clk_active[0] !== 1'b1 || ker_clk[0] !== 1'b0) begin errors++; $display("FAIL ch0_gate_rise act=%b clk=%b exp=1/0", clk_active[0], ker_clk[0]); end
    step();
    checks++; if (ker_clk[0] !== 1'b1) begin errors++; $display("FAIL ch0_first_rise got=%b exp=1", ker_clk[0]); end
    measure(0, hi, lo);
    checks++; if (hi != 1 || lo != 1) begin errors++; $display("FAIL ch0_div2 hi=%0d lo=%0d exp=1/1", hi, lo); end
    req(0, 4);
    acks = 0; ack_hi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (div_ack[0] === 1'b1) begin acks++; if (ker_clk[0] !== 1'b1) ack_hi = 1'b0; end
      step();
    end
    checks++; if (acks != 1 || ack_hi !== 1'b1) begin errors++; $display("FAIL ch0_ack acks=%0d at_high=%b exp=1/1", acks, ack_hi); end
    measure(0, hi, lo);
    checks++; if (hi != 5 || lo != 5) begin errors++; $display("FAIL ch0_div10 hi=%0d lo=%0d exp=5/5", hi, lo); end
    n = 0;
  endtask

  task automatic test_deepsleep();
    int n, hi;
    logic stayed_low;
    req(1, 3);
    checks++; if (div_ack[1] !== 1'b1) begin errors++; $display("FAIL ch1_idle_ack got=%b exp=1", div_ack[1]); end
    c1_en[1] = 1'b1;
    wait_rise(1, n);
    c1_deepsleep = 1'b1;
    hi = 1;
    step();
    while (ker_clk[1] === 1'b1 && hi < 50) begin hi++; step(); end
    checks++; if (hi != 4) begin errors++; $display("FAIL ch1_deepsleep_high hi=%0d exp=4", hi); end
    step();
    checks++; if (clk_active[1] !== 1'b0) begin errors++; $display("FAIL ch1_deepsleep_gate got=%b exp=0", clk_active[1]); end
    stayed_low = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ker_clk[1] !== 1'b0) stayed_low = 1'b0;
      step();
    end
    checks++; if (stayed_low !== 1'b1) begin errors++; $display("FAIL ch1_deepsleep_low got=%b exp=1", stayed_low); end
    c1_deepsleep = 1'b0;
    c1_en[1] = 1'b0;
    step();
  endtask

  task automatic test_stopped_req();
    int n;
    req(1, 6);
    checks++; if (div_ack[1] !== 1'b1) begin errors++; $display("FAIL ch1_stopped_ack got=%b exp=1", div_ack[1]); end
    step();
    checks++; if (div_ack[1] !== 1'b0) begin errors++; $display("FAIL ch1_ack_single got=%b exp=0", div_ack[1]); end
    c1_en[1] = 1'b1;
    step();
    checks++; if (clk_active[1] !== 1'b1) begin errors++; $display("FAIL ch1_gate_rise got=%b exp=1", clk_active[1]); end
    wait_rise(1, n);
    checks++; if (n != 7) begin errors++; $display("FAIL ch1_first_rise_delay got=%0d exp=7", n); end
  endtask

  task automatic test_rst_mid();
    int n, acks, hi, lo;
    // ch1 is at the first high cycle of a div-6 period
    step(); step();
    req(1, 2);
    checks++; if (div_ack[1] !== 1'b0 || ker_clk[1] !== 1'b1) begin errors++; $display("FAIL ch1_pre_rst ack=%b clk=%b exp=0/1", div_ack[1], ker_clk[1]); end
    rst = 1'b1;
    #1;
    checks++; if (ker_clk[1] !== 1'b0 || div_ack[1] !== 1'b0 || clk_active[1] !== 1'b0) begin errors++; $display("FAIL rst_async clk=%b ack=%b act=%b exp=0/0/0", ker_clk[1], div_ack[1], clk_active[1]); end
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (clk_active[1] !== 1'b1 || ker_clk[1] !== 1'b0) begin errors++; $display("FAIL post_rst_gate act=%b clk=%b exp=1/0", clk_active[1], ker_clk[1]); end
    step();
    checks++; if (ker_clk[1] !== 1'b1) begin errors++; $display("FAIL post_rst_first_rise got=%b exp=1", ker_clk[1]); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (div_ack[1] === 1'b1) acks++;
      step();
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL post_rst_no_ack acks=%0d exp=0", acks); end
    measure(1, hi, lo);
    checks++; if (hi != 1 || lo != 1) begin errors++; $display("FAIL post_rst_div hi=%0d lo=%0d exp=1/1", hi, lo); end
    n = 0;
  endtask

  task automatic test_sleep();
    int hi, lo;
    logic stayed_low;
    c1_en[2] = 1'b1; c1_lpen[2] = 1'b1; c1_sleep = 1'b1;
    measure(2, hi, lo);
    checks++; if (hi != 1 || lo != 1 || clk_active[2] !== 1'b1) begin errors++; $display("FAIL ch2_lpen_run hi=%0d lo=%0d act=%b exp=1/1/1", hi, lo, clk_active[2]); end
    c1_lpen[2] = 1'b0;
    step(); step(); step();
    checks++; if (clk_active[2] !== 1'b0) begin errors++; $display("FAIL ch2_sleep_stop got=%b exp=0", clk_active[2]); end
    stayed_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ker_clk[2] !== 1'b0) stayed_low = 1'b0;
      step();
    end
    checks++; if (stayed_low !== 1'b1) begin errors++; $display("FAIL ch2_sleep_low got=%b exp=1", stayed_low); end
    c2_en[2] = 1'b1;
    measure(2, hi, lo);
    checks++; if (hi != 1 || lo != 1) begin errors++; $display("FAIL ch2_core2_run hi=%0d lo=%0d exp=1/1", hi, lo); end
    c1_sleep = 1'b0; c1_en[2] = 1'b0; c2_en[2] = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    int n, acks, hi, lo;
    req(3, 5);
    checks++; if (div_ack[3] !== 1'b1) begin errors++; $display("FAIL ch3_idle_ack got=%b exp=1", div_ack[3]); end
    c1_en[3] = 1'b1;
    wait_rise(3, n);
    acks = 0;
    req(3, 2);
    if (div_ack[3] === 1'b1) acks++;
    req(3, 7);
    for (int i = 0; i < 30; i++) begin
      if (div_ack[3] === 1'b1) acks++;
      step();
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL ch3_single_ack acks=%0d exp=1", acks); end
    measure(3, hi, lo);
    checks++; if (hi != 8 || lo != 8) begin errors++; $display("FAIL ch3_div16 hi=%0d lo=%0d exp=8/8", hi, lo); end
    req(3, 7);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (div_ack[3] === 1'b1) acks++;
      step();
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL ch3_same_val_ack acks=%0d exp=1", acks); end
    measure(3, hi, lo);
    checks++; if (hi != 8 || lo != 8) begin errors++; $display("FAIL ch3_same_val_div hi=%0d lo=%0d exp=8/8", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_div2_then_div4();
    test_deepsleep();
    test_stopped_req();
    test_rst_mid();
    test_sleep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rcc_ker_clk_div_ctrl.md
RCC_KER_CLK_DIV_CTRL -- requirements
Module: rcc_ker_clk_div_ctrl

Interface
REQ-001 Parameter CH_NUM, default 4, number of independent kernel-clock channels (1..16).
REQ-002 Parameter DIV_W, default 5, width of per-channel half-period divider value.
REQ-003 Parameter DIV_RST, default 0, divider value loaded at reset.
REQ-004 clk_in  input  1  sole block clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep  input  1 each  core low-power states.
REQ-007 c1_en, c2_en, c1_lpen, c2_lpen  input  CH_NUM each  per-channel per-core enable / low-power enable.
REQ-008 div_req  input  CH_NUM  one-cycle divider change request per channel.
REQ-009 div_val  input  CH_NUM*DIV_W  requested divider per channel, channel i at bits [i*DIV_W +: DIV_W].
REQ-010 div_ack  output  CH_NUM  one-cycle pulse when requested divider takes effect.
REQ-011 ker_clk  output  CH_NUM  registered divided, gated kernel clock per channel.
REQ-012 clk_active  output  CH_NUM  per-channel gate state (1 = running).

Function
REQ-013 Per channel: en_raw = (c1_en & (~c1_sleep | c1_lpen) & ~c1_deepsleep) | (c2_en & (~c2_sleep | c2_lpen) & ~c2_deepsleep).
REQ-014 Per channel state: cnt (DIV_W bits), phase (1 bit, drives ker_clk directly), gate, div_cur, div_pend, pend flag.
REQ-015 Running (gate=1): cnt increments each cycle; at cnt==div_cur, cnt<=0 and phase toggles; period = 2*(div_cur+1) cycles, 50% duty; div_cur=0 gives divide-by-2.
REQ-016 gate updates to en_raw only in cycles where phase==0; gate never changes while ker_clk is high (no truncated high pulse).
REQ-017 Stopped (gate=0): cnt held 0, phase held 0; on restart first rising ker_clk occurs div_cur+1 cycles after gate rises.
REQ-018 Disable latency: deassertion of en_raw stops ker_clk within div_cur+2 cycles; ker_clk ends low.
REQ-019 div_req captures div_val into div_pend and sets pend; a further req while pend overwrites div_pend (single ack).
REQ-020 Apply point: pend set and (phase==1 and cnt==div_cur, i.e. falling boundary) or gate==0; div_cur<=div_pend, cnt<=0, pend cleared, div_ack pulses that cycle.
REQ-021 div_req in the apply cycle: current div_pend applied and acked; incoming value re-arms pend, acked at next apply point.
REQ-022 div_req value equal to div_cur still produces ack at apply point.
REQ-023 Channels fully independent; no cross-channel interaction.
REQ-024 clk_active = gate.

Reset
REQ-025 On rst: cnt=0, phase=0, gate=0, pend=0, div_pend=DIV_RST, div_cur=DIV_RST; ker_clk=0, div_ack=0, clk_active=0.
REQ-026 rst asserted mid-period forces ker_clk low immediately; pending request discarded, no ack.
REQ-027 After rst release, channel with en_raw=1 sets gate on first cycle and starts per REQ-017.

Structure
REQ-028 Package rcc_pkg holds CH_NUM and DIV_W defaults and the per-channel enable-equation function.
REQ-029 Per-channel logic in sub-module rcc_ker_div_ch, instantiated CH_NUM times by generate loop; top holds only enable decode and bus slicing.

Verification
REQ-030 c1_en[0]=1, div_cur=0 -> ker_clk[0] period 2 cycles; div_val=4 req -> ack at next falling boundary, then period 10 cycles, 5 high/5 low.
REQ-031 Channel running div=3, c1_deepsleep asserted while ker_clk high -> high phase completes to 4 cycles, ker_clk stays 0, clk_active=0 within 5 cycles.
REQ-032 c1_sleep=1 with c1_lpen=1 -> clock continues; c1_lpen=0 -> stops; c2_en=1 simultaneously -> continues via core 2.
REQ-033 Two div_req (values 2 then 7) before apply point -> single ack, resulting period 16 cycles.
REQ-034 Stopped channel, div_req value 6 -> ack next cycle; later enable -> first rising edge 7 cycles after gate rises.
REQ-035 rst pulsed mid-high-phase with pend set -> ker_clk=0 at once, no ack, div_cur=DIV_RST after release.
